umi_checker: RTL

Self-checking UMI receiver: the response-side counterpart of `umi_stimulus`. It sinks a UMI valid/ready stream from a DUT and applies a programmed backpressure pattern. Each accepted packet is compared against an expected-packet memory, and the block reports `done`, a sticky `error` and counters. It sits at the DUT output in UMI block benches and replaces the free-running ready toggle and `$display` monitor.

---
 rtl/umi_checker_pkg.sv | 20 ++
 rtl/umi_checker_mem.sv | 29 ++
 rtl/umi_checker.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/umi_checker_pkg.sv
// umi_checker_pkg: shared state type and expected-entry control field layout
// for the UMI response checker.
package umi_checker_pkg;

   // Checker sequencing states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STALL,
      ST_ACCEPT,
      ST_DONE
   } chk_state_t;

   // Control field layout inside each expected entry
   localparam int unsigned CHK_VALID_BIT = 0;
   localparam int unsigned CHK_CMP_BIT   = 1;
   localparam int unsigned CHK_STALL_LSB = 4;
   localparam int unsigned CHK_STALL_W   = 4;

endpackage

// File: rtl/umi_checker_mem.sv
// umi_checker_mem: expected-entry store for umi_checker. Each word is
// {ctrl, packet}; contents are preloaded into ram by the bench. Two
// asynchronous read ports: the full current entry and the control field of
// the following entry, so the checker can chain transfers without a bubble.
module umi_checker_mem
  #(parameter int UW     = 256,
    parameter int CW     = 8,
    parameter int DEPTH  = 1024,
    parameter     TARGET = "DEFAULT",
    localparam int AW    = $clog2(DEPTH))
   (input  logic [AW-1:0]    rd_addr,
    output logic [UW+CW-1:0] rd_entry,
    input  logic [AW-1:0]    la_addr,
    output logic [CW-1:0]    la_ctrl);

   logic [UW+CW-1:0] ram [0:DEPTH-1];

   // Every target maps onto the behavioural array; a hard macro would be
   // selected here for non-default targets.
   if (TARGET != "DEFAULT") begin : g_target
   end

   // Asynchronous read of the current entry and the look-ahead control field
   always_comb begin
      rd_entry = ram[rd_addr];
      la_ctrl  = ram[la_addr][UW +: CW];
   end

endmodule

// File: rtl/umi_checker.sv
// umi_checker: self-checking UMI receiver. Sinks a valid/ready stream,
// applies a per-entry programmed backpressure pattern and compares accepted
// packets against the expected-entry memory.
// Optional: define UMI_CHECKER_FIRSTERR_EN to capture the index of the first
// mismatching entry on err_index (tied to 0 otherwise).
module umi_checker
   import umi_checker_pkg::*;
  #(parameter int UW     = 256,
    parameter int CW     = 8,
    parameter int DEPTH  = 1024,
    parameter     TARGET = "DEFAULT",
    localparam int AW    = $clog2(DEPTH))
   (input  logic          clk,
    input  logic          nreset,
    input  logic          go,
    input  logic          umi_in_valid,
    input  logic [UW-1:0] umi_in_packet,
    output logic          umi_in_ready,
    output logic          done,
    output logic          error,
    output logic [15:0]   errcount,
    output logic [31:0]   rxcount,
    output logic [AW-1:0] err_index);

   chk_state_t             state;
   chk_state_t             state_nxt;
   logic [AW-1:0]          ptr;
   logic [AW-1:0]          ptr_nxt;
   logic [AW-1:0]          ptr_la;
   logic [CHK_STALL_W-1:0] cnt;
   logic [CHK_STALL_W-1:0] cnt_nxt;

   logic [UW+CW-1:0]       cur_entry;
   logic [CW-1:0]          cur_ctrl;
   logic [UW-1:0]          cur_pkt;
   logic [CW-1:0]          nxt_ctrl;
   logic [CHK_STALL_W-1:0] cur_stall;
   logic [CHK_STALL_W-1:0] nxt_stall;
   logic                   xfer;
   logic                   mismatch;
   logic                   ctrl_unused;

   assign ptr_la = ptr + AW'(1);

   umi_checker_mem #(.UW(UW), .CW(CW), .DEPTH(DEPTH), .TARGET(TARGET))
   u_mem (.rd_addr  (ptr),
          .rd_entry (cur_entry),
          .la_addr  (ptr_la),
          .la_ctrl  (nxt_ctrl));

   // Split the current entry and pick out the control fields
   always_comb begin
      cur_ctrl  = cur_entry[UW +: CW];
      cur_pkt   = cur_entry[UW-1:0];
      cur_stall = cur_ctrl[CHK_STALL_LSB +: CHK_STALL_W];
      nxt_stall = nxt_ctrl[CHK_STALL_LSB +: CHK_STALL_W];
   end

   // Reserved control bits are deliberately ignored
   assign ctrl_unused = ^{cur_ctrl, nxt_ctrl};

   // Next-state, pointer and stall counter
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      xfer      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (go) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            if (!cur_ctrl[CHK_VALID_BIT]) begin
               state_nxt = ST_DONE;
            end else if (cur_stall != '0) begin
               state_nxt = ST_STALL;
               cnt_nxt   = cur_stall - CHK_STALL_W'(1);
            end else begin
               state_nxt = ST_ACCEPT;
            end
         end
         ST_STALL: begin
            if (cnt == '0) state_nxt = ST_ACCEPT;
            else           cnt_nxt   = cnt - CHK_STALL_W'(1);
         end
         ST_ACCEPT: begin
            if (umi_in_valid && umi_in_ready) begin
               xfer    = 1'b1;
               ptr_nxt = ptr_la;
               if ((ptr == AW'(DEPTH - 1)) || !nxt_ctrl[CHK_VALID_BIT]) begin
                  state_nxt = ST_DONE;
               end else if (nxt_stall != '0) begin
                  // Stalling after a transfer holds ready low stall+1 cycles,
                  // one more than after LOAD; a zero stall keeps ready high.
                  state_nxt = ST_STALL;
                  cnt_nxt   = nxt_stall;
               end
            end
         end
         ST_DONE: begin
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign mismatch = xfer && cur_ctrl[CHK_CMP_BIT] && (umi_in_packet != cur_pkt);

   // State register with registered ready and sticky done
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state        <= ST_IDLE;
         ptr          <= '0;
         cnt          <= '0;
         umi_in_ready <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_nxt;
         ptr          <= ptr_nxt;
         cnt          <= cnt_nxt;
         umi_in_ready <= (state_nxt == ST_ACCEPT);
         done         <= done | (state_nxt == ST_DONE);
      end
   end

   // Transfer and mismatch accounting
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         rxcount  <= '0;
         errcount <= '0;
         error    <= 1'b0;
      end else begin
         if (xfer) rxcount <= rxcount + 32'd1;
         if (mismatch) begin
            error <= 1'b1;
            if (errcount != 16'hFFFF) errcount <= errcount + 16'd1;
         end
      end
   end

`ifdef UMI_CHECKER_FIRSTERR_EN
   // Capture the entry index of the first mismatch only
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)                 err_index <= '0;
      else if (mismatch && !error) err_index <= ptr;
   end
`else
   assign err_index = '0;
`endif

endmodule
